// File: rtl/cpu_bus_sequencer.sv
// CPU bus timing and address decode engine for the 65C02 SoC: divides clk into CPU
// periods, decodes regions, stretches cycles by per-region wait states, captures read data.
module cpu_bus_sequencer #(
    parameter int CLKEN_BITS  = 2,
    parameter int NUM_REGIONS = 4,
    parameter int WAIT_BITS   = 4,
    parameter int EXT_WAIT    = 0
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic [15:0]                      i_cpu_addr,
    input  logic                             i_cpu_we,
    input  logic [16*NUM_REGIONS-1:0]        i_cfg_base,
    input  logic [16*NUM_REGIONS-1:0]        i_cfg_mask,
    input  logic [WAIT_BITS*NUM_REGIONS-1:0] i_cfg_wait,
    input  logic [8*NUM_REGIONS-1:0]         i_rgn_din,
    input  logic [7:0]                       i_bus_din,
    output logic                             o_cpu_clken,
    output logic                             o_per_clken,
    output logic                             o_phi2,
    output logic [NUM_REGIONS-1:0]           o_sel,
    output logic [NUM_REGIONS-1:0]           o_sel_we,
    output logic                             o_bus_e,
    output logic [7:0]                       o_cpu_din,
    output logic                             o_stretch
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CLKEN_BITS-1:0]  r_ctr;
    logic                   w_tick;
    logic [WAIT_BITS-1:0]   r_wcnt;
    logic [WAIT_BITS-1:0]   w_wcnt_nxt;
    logic                   r_cpu_clken;
    logic                   w_clken_nxt;
    logic                   r_per_clken;
    logic                   r_rst_q;
    logic [7:0]             r_cpu_din;
    logic [7:0]             w_din_sel;
    logic [WAIT_BITS-1:0]   w_wait_sel;
    logic [NUM_REGIONS-1:0] w_hits;
    logic [NUM_REGIONS-1:0] w_sel;

    // Free-running period divider; deliberately outside the reset domain.
    always_ff @(posedge i_clk) begin
        r_ctr <= r_ctr + CLKEN_BITS'(1);
    end

    assign w_tick = &r_ctr;

    // Region decode: scanning from the top down lets the lowest index win.
    always_comb begin
        w_hits     = '0;
        w_sel      = '0;
        w_wait_sel = WAIT_BITS'(EXT_WAIT);
        w_din_sel  = i_bus_din;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            w_hits[i] = ((i_cpu_addr & i_cfg_mask[16*i +: 16]) ==
                         (i_cfg_base[16*i +: 16] & i_cfg_mask[16*i +: 16]));
        end
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_hits[i]) begin
                w_sel      = '0;
                w_sel[i]   = 1'b1;
                w_wait_sel = i_cfg_wait[WAIT_BITS*i +: WAIT_BITS];
                w_din_sel  = i_rgn_din[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_clken_nxt = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_tick) begin
                    if (w_wait_sel == '0) begin
                        w_clken_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_wcnt_nxt  = w_wait_sel;
                    end
                end
            end
            S_WAIT: begin
                if (w_tick) begin
                    if (r_wcnt <= WAIT_BITS'(1)) begin
                        w_clken_nxt = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_wcnt_nxt = r_wcnt - WAIT_BITS'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // During reset the CPU still gets a clock enable every period (after the
    // first reset clk) so its reset vector sequence can advance.
    always_ff @(posedge i_clk) begin
        r_rst_q <= i_reset;
        if (i_reset) begin
            r_state     <= S_RUN;
            r_wcnt      <= '0;
            r_cpu_din   <= '0;
            r_per_clken <= 1'b0;
            r_cpu_clken <= w_tick & r_rst_q;
        end else begin
            r_state     <= w_state_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_cpu_clken <= w_clken_nxt;
            r_per_clken <= r_cpu_clken;
            if (w_clken_nxt) begin
                r_cpu_din <= w_din_sel;
            end
        end
    end

    assign o_cpu_clken = r_cpu_clken;
    assign o_per_clken = r_per_clken;
    assign o_phi2      = r_ctr[CLKEN_BITS-1] | (r_state == S_WAIT);
    assign o_stretch   = (r_state == S_WAIT);
    assign o_sel       = w_sel;
    assign o_sel_we    = w_sel & {NUM_REGIONS{i_cpu_we}};
    assign o_bus_e     = ~|w_hits;
    assign o_cpu_din   = r_cpu_din;

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Bench for cpu_bus_sequencer: directed scenarios plus randomized accesses, each
// checked against an access-level timing model derived from the decode/wait rules.
module tb_cpu_bus_sequencer;

    localparam int NR   = 4;
    localparam int WB   = 4;
    localparam int EXTW = 1;

    logic              clk;
    logic              reset;
    logic [15:0]       cpu_addr;
    logic              cpu_we;
    logic [16*NR-1:0]  cfg_base;
    logic [16*NR-1:0]  cfg_mask;
    logic [WB*NR-1:0]  cfg_wait;
    logic [8*NR-1:0]   rgn_din;
    logic [7:0]        bus_din;
    logic              cpu_clken;
    logic              per_clken;
    logic              phi2;
    logic [NR-1:0]     sel;
    logic [NR-1:0]     sel_we;
    logic              bus_e;
    logic [7:0]        cpu_din;
    logic              stretch;

    cpu_bus_sequencer #(
        .CLKEN_BITS (2),
        .NUM_REGIONS(NR),
        .WAIT_BITS  (WB),
        .EXT_WAIT   (EXTW)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_cpu_addr (cpu_addr),
        .i_cpu_we   (cpu_we),
        .i_cfg_base (cfg_base),
        .i_cfg_mask (cfg_mask),
        .i_cfg_wait (cfg_wait),
        .i_rgn_din  (rgn_din),
        .i_bus_din  (bus_din),
        .o_cpu_clken(cpu_clken),
        .o_per_clken(per_clken),
        .o_phi2     (phi2),
        .o_sel      (sel),
        .o_sel_we   (sel_we),
        .o_bus_e    (bus_e),
        .o_cpu_din  (cpu_din),
        .o_stretch  (stretch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] base  [NR];
    logic [15:0] mask  [NR];
    logic [3:0]  waitv [NR];
    logic [7:0]  rdat  [NR];
    logic [7:0]  m_din;
    logic [15:0] mtab  [6] = '{16'h0000, 16'h8000, 16'hF000, 16'hFF00, 16'hFFF0, 16'hFFFF};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg();
        for (int i = 0; i < NR; i++) begin
            cfg_base[16*i +: 16] = base[i];
            cfg_mask[16*i +: 16] = mask[i];
            cfg_wait[WB*i +: WB] = waitv[i];
            rgn_din[8*i +: 8]    = rdat[i];
        end
    endtask

    // Every region matches only FFFF and has no waits.
    task automatic clear_cfg();
        for (int i = 0; i < NR; i++) begin
            base[i]  = 16'hFFFF;
            mask[i]  = 16'hFFFF;
            waitv[i] = 4'd0;
            rdat[i]  = 8'($urandom);
        end
    endtask

    function automatic int decode(input logic [15:0] a);
        for (int i = 0; i < NR; i++) begin
            if ((a & mask[i]) == (base[i] & mask[i])) return i;
        end
        return -1;
    endfunction

    // Entered at a sample point where cpu_clken is high; runs one full access.
    task automatic run_access(input string tag, input logic [15:0] addr,
                              input logic we, input logic [7:0] newdat);
        int         idx;
        int         w;
        int         k;
        int         per_cnt;
        int         st_cnt;
        int         phi_mm;
        bit         done;
        bit         exp_phi;
        logic [3:0] exp_sel;
        drive_cfg();
        cpu_addr = addr;
        cpu_we   = we;
        #1;
        idx     = decode(addr);
        w       = (idx < 0) ? EXTW : int'(waitv[idx]);
        exp_sel = (idx < 0) ? 4'b0000 : 4'(1 << idx);
        chk({tag, "_sel"}, 32'(sel), 32'(exp_sel));
        chk({tag, "_sel_we"}, 32'(sel_we), 32'(we ? exp_sel : 4'b0000));
        chk({tag, "_bus_e"}, 32'(bus_e), 32'(idx < 0));
        k = 0; per_cnt = 0; st_cnt = 0; phi_mm = 0; done = 1'b0;
        while (!done && k < 100) begin
            step();
            k++;
            if (k == 1) chk({tag, "_per_pos"}, 32'(per_clken), 32'd1);
            if (per_clken === 1'b1) per_cnt++;
            if (stretch === 1'b1) st_cnt++;
            exp_phi = ((k % 4) >= 2) || (k >= 4 && k <= 4*w + 3);
            if (phi2 !== exp_phi) phi_mm++;
            if (cpu_clken === 1'b1) begin
                done = 1'b1;
            end else begin
                if (k == 4*w + 3) chk({tag, "_din_hold"}, 32'(cpu_din), 32'(m_din));
                if (k == 2) begin
                    if (idx < 0) bus_din = newdat;
                    else rdat[idx] = newdat;
                    drive_cfg();
                end
                if (k == 5 && w > 0 && idx >= 0) begin
                    waitv[idx] = 4'($urandom_range(0, 15));
                    drive_cfg();
                end
            end
        end
        chk({tag, "_spacing"}, 32'(k), 32'(4*(w+1)));
        chk({tag, "_per_cnt"}, 32'(per_cnt), 32'd1);
        chk({tag, "_stretch_cnt"}, 32'(st_cnt), 32'(4*w));
        chk({tag, "_phi2"}, 32'(phi_mm), 32'd0);
        chk({tag, "_din"}, 32'(cpu_din), 32'(newdat));
        m_din = newdat;
    endtask

    initial begin
        int  mm;
        int  per_mm;
        int  found;
        int  k;
        reset    = 1'b1;
        cpu_addr = 16'h0000;
        cpu_we   = 1'b0;
        bus_din  = 8'h00;
        m_din    = 8'h00;
        clear_cfg();
        mask[0] = 16'h0000;
        drive_cfg();
        step();
        step();

        // Lock onto the divider phase using the reset-time enable pulses.
        found = 0;
        for (int i = 0; i < 16 && found == 0; i++) begin
            step();
            if (cpu_clken === 1'b1) found = 1;
        end
        chk("rst_sync_pulse", 32'(found), 32'd1);
        chk("rst_din", 32'(cpu_din), 32'h0);
        chk("rst_per", 32'(per_clken), 32'd0);
        chk("rst_stretch", 32'(stretch), 32'd0);
        mm = 0; per_mm = 0;
        for (int j = 1; j <= 8; j++) begin
            step();
            if (cpu_clken !== ((j % 4) == 0)) mm++;
            if (per_clken !== 1'b0) per_mm++;
        end
        chk("rst_clken_every4", 32'(mm), 32'd0);
        chk("rst_per_quiet", 32'(per_mm), 32'd0);
        reset = 1'b0;

        // T1: every address hits region 0 with no waits.
        run_access("t1a", 16'h0100, 1'b0, 8'h11);
        run_access("t1b", 16'($urandom), 1'b0, 8'($urandom));
        run_access("t1c", 16'($urandom), 1'b1, 8'($urandom));

        clear_cfg();
        base[0] = 16'h0000; mask[0] = 16'h8000; waitv[0] = 4'd0;
        run_access("t2", 16'h1234, 1'b0, 8'h5A);

        clear_cfg();
        base[0] = 16'h0000; mask[0] = 16'h8000; waitv[0] = 4'd0;
        base[2] = 16'h8800; mask[2] = 16'hFFF0; waitv[2] = 4'd3;
        run_access("t3", 16'h8805, 1'b0, 8'hA7);

        clear_cfg();
        base[0] = 16'h8000; mask[0] = 16'hF000; waitv[0] = 4'd0;
        base[1] = 16'h8000; mask[1] = 16'hFF00; waitv[1] = 4'd2;
        run_access("t4", 16'h8000, 1'b1, 8'h3C);

        clear_cfg();
        base[0] = 16'h0000; mask[0] = 16'h8000;
        base[2] = 16'h8800; mask[2] = 16'hFFF0; waitv[2] = 4'd3;
        run_access("t5", 16'h9000, 1'b0, 8'hC3);

        for (int r = 0; r < 20; r++) begin
            logic [15:0] a;
            for (int i = 0; i < NR; i++) begin
                base[i]  = 16'($urandom);
                mask[i]  = mtab[$urandom_range(0, 5)];
                waitv[i] = 4'($urandom_range(0, 4));
                rdat[i]  = 8'($urandom);
            end
            a = ($urandom_range(0, 1) == 0) ? base[$urandom_range(0, NR-1)] : 16'($urandom);
            run_access("rnd", a, 1'($urandom), 8'($urandom));
        end

        // T6: reset arrives two periods into a 7-wait access.
        clear_cfg();
        mask[0] = 16'h0000; waitv[0] = 4'd7;
        drive_cfg();
        cpu_addr = 16'h4321;
        cpu_we   = 1'b0;
        for (k = 1; k <= 12; k++) step();
        chk("t6_stretch_pre", 32'(stretch), 32'd1);
        reset = 1'b1;
        step();
        chk("t6_stretch_drop", 32'(stretch), 32'd0);
        chk("t6_din_clear", 32'(cpu_din), 32'h0);
        mm = 0; per_mm = 0;
        if (cpu_clken !== 1'b0) mm++;
        for (k = 14; k <= 24; k++) begin
            step();
            if (cpu_clken !== ((k % 4) == 0)) mm++;
            if (per_clken !== 1'b0 || stretch !== 1'b0 || cpu_din !== 8'h00) per_mm++;
        end
        chk("t6_rst_clken_every4", 32'(mm), 32'd0);
        chk("t6_rst_quiet", 32'(per_mm), 32'd0);
        m_din = 8'h00;
        reset = 1'b0;
        waitv[0] = 4'd1;
        run_access("t6_recover", 16'h2000, 1'b0, 8'h96);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
